// File: rtl/platform_spawner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// platform_spawner
//
// Keeps a table of NUM_PLAT platform slots (x, y, valid) for the game screen.
//   * start      : fills every slot, one per clock, with a random x taken from
//                  the LFSR and y = slot * SPACING.
//   * scroll_req : walks the table one slot per clock, moving every valid
//                  platform down by dy. A platform that falls off the bottom
//                  comes back at the top (y wraps modulo SCREEN_H) with a fresh
//                  random x, and respawn_cnt counts it.
//   * The drawing logic reads any slot through a combinational read port.
//
// Ports:
//   Clk          in   1      system clock
//   Reset        in   1      asynchronous active-high reset
//   rand_in      in   9      LFSR word, new value every clock
//   start        in   1      request a full table fill
//   scroll_req   in   1      request a scroll pass
//   scroll_dy    in   10     scroll distance, sampled with scroll_req
//   rd_idx       in   PW     slot select for the read port
//   rd_x         out  10     x of the selected slot
//   rd_y         out  10     y of the selected slot
//   rd_valid     out  1      valid bit of the selected slot
//   busy         out  1      high whenever a fill or scroll pass is running
//   done         out  1      one-cycle pulse in the first idle cycle after a pass
//   respawn_cnt  out  8      number of respawns, wraps 255 -> 0
// -----------------------------------------------------------------------------
module platform_spawner #(
  parameter int NUM_PLAT = 8,
  parameter int SPACING  = 60,
  parameter int SCREEN_H = 480,
  parameter int X_MAX    = 575,
  localparam int PW      = $clog2(NUM_PLAT)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [8:0]    rand_in,
  input  logic          start,
  input  logic          scroll_req,
  input  logic [9:0]    scroll_dy,
  input  logic [PW-1:0] rd_idx,
  output logic [9:0]    rd_x,
  output logic [9:0]    rd_y,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic [7:0]    respawn_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_SCROLL = 2'd2
  } state_t;

  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_PLAT - 1);
  localparam logic [10:0]   SH11     = 11'(SCREEN_H);
  localparam logic [9:0]    DY_MAX   = 10'(SCREEN_H - 1);

  // Fold an LFSR word into the legal x range [0, X_MAX]. Values above X_MAX
  // are shifted down by one screen-width worth rather than clipped, so the
  // top of the random range does not pile up on the right edge.
  function automatic logic [9:0] remap(input logic [8:0] r);
    logic [9:0] v;
    v = {1'b0, r};
    if (v <= 10'(X_MAX))
      remap = v;
    else
      remap = v - 10'(X_MAX + 1);
  endfunction

  // Scroll distances of a full screen or more would wrap more than once;
  // limit to one screen height minus one.
  function automatic logic [9:0] clamp_dy(input logic [9:0] dy);
    if (dy > DY_MAX)
      clamp_dy = DY_MAX;
    else
      clamp_dy = dy;
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic [PW-1:0]         r_ptr;
  logic [9:0]            r_dy;
  logic [9:0]            r_x [NUM_PLAT];
  logic [9:0]            r_y [NUM_PLAT];
  logic [NUM_PLAT-1:0]   r_valid;
  logic                  r_done;
  logic [7:0]            r_cnt;

  logic                  w_last;
  logic [9:0]            w_rmx;
  logic [9:0]            w_fill_y;
  logic [10:0]           w_sum;
  logic                  w_wrap;
  logic [9:0]            w_wrap_y;
  logic [9:0]            w_sum_y;

  assign w_last   = (r_ptr == LAST_PTR);
  assign w_rmx    = remap(rand_in);
  assign w_fill_y = 10'(int'(r_ptr) * SPACING);

  // 11-bit sum so y + dy cannot overflow before the wrap test.
  assign w_sum    = {1'b0, r_y[r_ptr]} + {1'b0, r_dy};
  assign w_wrap   = (w_sum >= SH11);
  assign w_wrap_y = 10'(w_sum - SH11);
  assign w_sum_y  = 10'(w_sum);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. start has priority over scroll_req; requests that
  // arrive outside IDLE are simply not looked at.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start)
          w_next = S_FILL;
        else if (scroll_req)
          w_next = S_SCROLL;
      end
      S_FILL, S_SCROLL: begin
        if (w_last)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (r_state != S_IDLE);
    done = r_done;
  end

  // ---------------------------------------------------------------------------
  // Slot table, pointer, scroll distance and respawn counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ptr   <= '0;
      r_dy    <= '0;
      r_valid <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < NUM_PLAT; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      // The final slot write and the return to IDLE share an edge, so done
      // lands in the first idle cycle.
      r_done <= (r_state != S_IDLE) && w_last;
      case (r_state)
        S_IDLE: begin
          r_ptr <= '0;
          if (!start && scroll_req)
            r_dy <= clamp_dy(scroll_dy);
        end
        S_FILL: begin
          r_x[r_ptr]     <= w_rmx;
          r_y[r_ptr]     <= w_fill_y;
          r_valid[r_ptr] <= 1'b1;
          r_ptr          <= r_ptr + 1'b1;
        end
        S_SCROLL: begin
          if (r_valid[r_ptr]) begin
            if (w_wrap) begin
              r_y[r_ptr] <= w_wrap_y;
              r_x[r_ptr] <= w_rmx;
              r_cnt      <= r_cnt + 8'd1;
            end else begin
              r_y[r_ptr] <= w_sum_y;
            end
          end
          r_ptr <= r_ptr + 1'b1;
        end
        default: r_ptr <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: straight from the table, no latency
  // ---------------------------------------------------------------------------
  assign rd_x        = r_x[rd_idx];
  assign rd_y        = r_y[rd_idx];
  assign rd_valid    = r_valid[rd_idx];
  assign respawn_cnt = r_cnt;

endmodule

// File: tb/tb_platform_spawner.sv
`timescale 1ns/1ps
module tb_platform_spawner;

  logic       Clk;
  logic       Reset;
  logic [8:0] rand_in;
  logic       start;
  logic       scroll_req;
  logic [9:0] scroll_dy;
  logic [2:0] rd_idx;

  logic [9:0] rd_x_a, rd_y_a, rd_x_b, rd_y_b;
  logic       rd_valid_a, rd_valid_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] cnt_a, cnt_b;

  // Default instance (X_MAX=575) and a narrow-screen instance (X_MAX=300)
  // driven by the same stimulus.
  platform_spawner u_dut_a (
    .Clk(Clk), .Reset(Reset), .rand_in(rand_in), .start(start),
    .scroll_req(scroll_req), .scroll_dy(scroll_dy), .rd_idx(rd_idx),
    .rd_x(rd_x_a), .rd_y(rd_y_a), .rd_valid(rd_valid_a),
    .busy(busy_a), .done(done_a), .respawn_cnt(cnt_a)
  );

  platform_spawner #(.X_MAX(300)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .rand_in(rand_in), .start(start),
    .scroll_req(scroll_req), .scroll_dy(scroll_dy), .rd_idx(rd_idx),
    .rd_x(rd_x_b), .rd_y(rd_y_b), .rd_valid(rd_valid_b),
    .busy(busy_b), .done(done_b), .respawn_cnt(cnt_b)
  );

  typedef struct packed {
    logic [7:0][9:0] xa;
    logic [7:0][9:0] ya;
    logic [7:0][9:0] xb;
    logic [7:0][9:0] yb;
    logic [7:0]      va;
    logic [7:0]      vb;
    logic [7:0]      ca;
    logic [7:0]      cb;
  } snap_t;

  snap_t model;
  snap_t exp_q[$];
  int    n_err;
  int    n_chk;
  int    rv[8];
  bit    clk_run;

  initial begin
    Clk = 1'b0;
    wait (clk_run);
    forever #5 Clk = ~Clk;
  end

  function automatic void chk(input string nm, input int idx, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s[%0d]: actual=%0d required=%0d", nm, idx, act, req);
    end
  endfunction

  function automatic int rm(input int r, input int xm);
    return (r <= xm) ? r : r - (xm + 1);
  endfunction

  // Expected table after a fill using rand words rv[0..7].
  function automatic void m_fill();
    for (int i = 0; i < 8; i++) begin
      model.xa[i] = 10'(rm(rv[i], 575));
      model.xb[i] = 10'(rm(rv[i], 300));
      model.ya[i] = 10'(60 * i);
      model.yb[i] = 10'(60 * i);
      model.va[i] = 1'b1;
      model.vb[i] = 1'b1;
    end
  endfunction

  // Expected table after a scroll by dy using rand words rv[0..7].
  function automatic void m_scroll(input int dy);
    int d, s;
    d = (dy > 479) ? 479 : dy;
    for (int i = 0; i < 8; i++) begin
      if (model.va[i]) begin
        s = int'(model.ya[i]) + d;
        if (s >= 480) begin
          model.ya[i] = 10'(s - 480);
          model.xa[i] = 10'(rm(rv[i], 575));
          model.ca    = model.ca + 8'd1;
        end else begin
          model.ya[i] = 10'(s);
        end
      end
      if (model.vb[i]) begin
        s = int'(model.yb[i]) + d;
        if (s >= 480) begin
          model.yb[i] = 10'(s - 480);
          model.xb[i] = 10'(rm(rv[i], 300));
          model.cb    = model.cb + 8'd1;
        end else begin
          model.yb[i] = 10'(s);
        end
      end
    end
  endfunction

  // Monitor: compares the whole table whenever a pass completes (done) or
  // while Reset is held.
  task automatic compare(input bit is_rst);
    snap_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL unexpected_done: actual done_a=%0d done_b=%0d, required no pulse", done_a, done_b);
      return;
    end
    e = exp_q.pop_front();
    chk("busy_a", 0, busy_a, 0);
    chk("busy_b", 0, busy_b, 0);
    chk("done_a", 0, done_a, is_rst ? 0 : 1);
    chk("done_b", 0, done_b, is_rst ? 0 : 1);
    chk("cnt_a", 0, cnt_a, e.ca);
    chk("cnt_b", 0, cnt_b, e.cb);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #0.1;
      chk("x_a", i, rd_x_a, e.xa[i]);
      chk("y_a", i, rd_y_a, e.ya[i]);
      chk("v_a", i, rd_valid_a, e.va[i]);
      chk("x_b", i, rd_x_b, e.xb[i]);
      chk("y_b", i, rd_y_b, e.yb[i]);
      chk("v_b", i, rd_valid_b, e.vb[i]);
    end
  endtask

  initial begin
    forever begin
      @(negedge Clk or posedge Reset);
      if (Reset) begin
        #1;
        compare(1'b1);
      end else if (done_a || done_b) begin
        compare(1'b0);
      end
    end
  end

  // Issue one fill or scroll pass. Called at posedge+1. poke raises start
  // and scroll_req mid-pass, which must be ignored.
  task automatic do_op(input bit is_fill, input bit both, input int dy, input bit poke);
    int nb;
    if (is_fill) m_fill();
    else m_scroll(dy);
    exp_q.push_back(model);
    start      = is_fill;
    scroll_req = !is_fill || both;
    scroll_dy  = 10'(dy);
    @(posedge Clk); #1;
    start      = 1'b0;
    scroll_req = 1'b0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      rand_in    = 9'(rv[i]);
      if (busy_a) nb++;
      start      = poke && (i == 3);
      scroll_req = poke && (i == 3 || i == 4);
      @(posedge Clk); #1;
    end
    start      = 1'b0;
    scroll_req = 1'b0;
    chk("busy_cycles", 0, nb, 8);
    chk("busy_end", 0, busy_a, 0);
    @(posedge Clk); #1;
  endtask

  initial begin
    int nd;
    n_err = 0;
    n_chk = 0;
    clk_run = 1'b0;
    Reset = 1'b0; start = 1'b0; scroll_req = 1'b0; scroll_dy = '0; rand_in = '0;
    model = '0;

    // Reset with no clock running: everything reads zero immediately.
    exp_q.push_back(model);
    #3 Reset = 1'b1;
    #3 Reset = 1'b0;
    #4 clk_run = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // Fill with 10,20,...,80.
    for (int i = 0; i < 8; i++) rv[i] = 10 * (i + 1);
    do_op(1'b1, 1'b0, 0, 1'b0);

    // Scroll by 100 with rand 333: only slot 7 wraps (A x=333, B x=32).
    for (int i = 0; i < 8; i++) rv[i] = 333;
    do_op(1'b0, 1'b0, 100, 1'b0);

    // start and scroll_req together: fill only; remap boundaries on B; pokes ignored.
    rv = '{400, 300, 301, 511, 0, 1, 299, 302};
    do_op(1'b1, 1'b1, 50, 1'b1);

    // dy=0 scroll: nothing moves, done still pulses; pokes ignored.
    do_op(1'b0, 1'b0, 0, 1'b1);

    // Reset at cycle 3 of a fill: table cleared, no done pulse.
    for (int i = 0; i < 8; i++) rv[i] = 5 + i;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_in = 9'(rv[i]);
      @(posedge Clk); #1;
    end
    exp_q.delete();
    model = '0;
    exp_q.push_back(model);
    Reset = 1'b1;
    #3 Reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      if (done_a || done_b) nd++;
    end
    chk("abort_done", 0, nd, 0);
    chk("abort_busy", 0, busy_a, 0);

    // Fresh fill, then scroll by 900 (clamped to 479): all but y=0 wrap.
    rv = '{7, 77, 177, 277, 377, 477, 311, 411};
    do_op(1'b1, 1'b0, 0, 1'b0);
    rv = '{450, 320, 301, 12, 500, 299, 301, 400};
    do_op(1'b0, 1'b0, 900, 1'b0);

    repeat (3) @(posedge Clk);
    #1;
    chk("pending", 0, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
